program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// CPU-side handshake bundle between the program loader (master) and the target
// CPU (slave): programming-mode strobe, byte bus, ready_for_ui and done-loading.
interface program_loader_if;
    logic       prog;
    logic [7:0] ui_data;
    logic       cpu_ready;
    logic       cpu_done_load;

    modport master (
        output prog,
        output ui_data,
        input  cpu_ready,
        input  cpu_done_load
    );

    modport slave (
        input  prog,
        input  ui_data,
        output cpu_ready,
        output cpu_done_load
    );
endinterface

// File: rtl/program_loader.sv
// Streams a DEPTH-byte image from a local register buffer into a CPU over the
// ready_for_ui handshake, with timeout, early-done and abort detection.
module program_loader #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 start,
    input  logic                 abort,
    program_loader_if.master     cpu,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [4:0]           byte_cnt
);
    localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            TW          = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TC_LAST     = TW'(TIMEOUT - 1);
    localparam logic [4:0]    CNT_MAX     = 5'(DEPTH);
    localparam logic [1:0]    ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]    ERR_EARLY   = 2'b10;
    localparam logic [1:0]    ERR_ABORT   = 2'b11;

    typedef enum logic [2:0] {IDLE, ARM, SEND, WAIT_DONE, FINISH, FAIL} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    image [DEPTH];
    logic [AW-1:0] ptr;
    logic [TW-1:0] tcnt;
    logic          ready_q;
    logic          consumed;
    logic          tc_hit;
    logic          accept;
    logic          fail_now;
    logic [1:0]    fail_code;

    assign accept   = (state == IDLE) && start && !abort;
    assign consumed = (state == SEND) && ready_q && !cpu.cpu_ready;
    assign tc_hit   = (tcnt == TC_LAST);

    // Image buffer has no reset so a loaded image survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && ({28'd0, wr_addr} < 32'(DEPTH)))
            image[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        fail_now   = 1'b0;
        fail_code  = 2'b00;
        case (state)
            IDLE:      if (accept) state_next = ARM;
            ARM:       state_next = SEND;
            SEND: begin
                if (consumed) begin
                    if (ptr == PTR_LAST) state_next = WAIT_DONE;
                end else if (cpu.cpu_done_load) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_EARLY;
                end else if (tc_hit) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            WAIT_DONE: begin
                if (cpu.cpu_done_load) begin
                    state_next = FINISH;
                end else if (tc_hit) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            FINISH:    state_next = IDLE;
            FAIL:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // Abort overrides every other event once a load is under way.
        if (abort && (state != IDLE) && (state != FAIL)) begin
            fail_now  = 1'b1;
            fail_code = ERR_ABORT;
        end
        if (fail_now) state_next = FAIL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            tcnt     <= '0;
            ready_q  <= 1'b0;
            byte_cnt <= 5'd0;
            error    <= 1'b0;
            err_code <= 2'b00;
        end else begin
            ready_q <= cpu.cpu_ready;
            if (accept) begin
                error    <= 1'b0;
                err_code <= 2'b00;
                byte_cnt <= 5'd0;
                ptr      <= '0;
            end
            if (state == ARM) ptr <= '0;
            if (consumed) begin
                if (ptr != PTR_LAST) ptr <= ptr + AW'(1);
                if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 5'd1;
            end
            // A consumed byte on the terminal count still restarts the window.
            if ((state_next != state) || consumed)
                tcnt <= '0;
            else if ((state == SEND) || (state == WAIT_DONE))
                tcnt <= tcnt + TW'(1);
            if (fail_now) begin
                error    <= 1'b1;
                err_code <= fail_code;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign cpu.prog    = (state == ARM) || (state == SEND) || (state == WAIT_DONE);
    assign cpu.ui_data = (state == SEND) ? image[ptr] : 8'h00;
endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader: a CPU model drives the
// handshake, and a monitor checks each consumed byte and each load outcome.
module tb_program_loader;
    localparam int DEPTH      = 16;
    localparam int TIMEOUT    = 255;
    localparam int SC_FULL    = 0;
    localparam int SC_TIMEOUT = 1;
    localparam int SC_EARLY   = 2;
    localparam int SC_ABORT   = 3;
    localparam int SC_RESET   = 4;

    typedef struct packed {
        logic [1:0] dones;
        logic       error;
        logic [1:0] code;
        logic [4:0] cnt;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [4:0] byte_cnt;

    logic [7:0] model_img [DEPTH];
    logic [7:0] exp_bytes [$];
    result_t    exp_res [$];
    int         tests = 0;
    int         fails = 0;

    program_loader_if cpu ();

    program_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .abort    (abort),
        .cpu      (cpu),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeImage(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        model_img[addr] = data;
    endtask

    task automatic randomImage();
        for (int i = 0; i < DEPTH; i++) writeImage(i, 8'($urandom_range(0, 255)));
    endtask

    // CPU model: one ready_for_ui pulse of random width after a random gap.
    task automatic cpuByte();
        repeat ($urandom_range(0, 2)) tick();
        cpu.cpu_ready = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        cpu.cpu_ready = 1'b0;
        tick();
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("return_idle", busy, 0);
    endtask

    task automatic applyStimulus(input int kind, input int k);
        result_t r;
        int      n;
        int      cyc;
        n = (kind == SC_FULL) ? DEPTH : (kind == SC_TIMEOUT) ? 0 : k;
        for (int i = 0; i < n; i++) exp_bytes.push_back(model_img[i]);
        r.dones = (kind == SC_FULL) ? 2'd1 : 2'd0;
        r.error = (kind == SC_FULL || kind == SC_RESET) ? 1'b0 : 1'b1;
        case (kind)
            SC_TIMEOUT: r.code = 2'b01;
            SC_EARLY:   r.code = 2'b10;
            SC_ABORT:   r.code = 2'b11;
            default:    r.code = 2'b00;
        endcase
        r.cnt = (kind == SC_FULL) ? 5'(DEPTH) :
                (kind == SC_TIMEOUT || kind == SC_RESET) ? 5'd0 : 5'(k);
        exp_res.push_back(r);

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_to_prog", cpu.prog, 1);

        if (kind == SC_TIMEOUT) begin
            cyc = 0;
            while (!error && cyc < 2 * TIMEOUT) begin
                tick();
                cyc++;
            end
            tests++;
            if (cyc < TIMEOUT || cyc > TIMEOUT + 2) begin
                fails++;
                $display("[TB] FAIL timeout_latency: got %0d cycles, required %0d..%0d", cyc, TIMEOUT, TIMEOUT + 2);
            end
        end else begin
            tick();
            for (int i = 0; i < n; i++) begin
                if (kind == SC_FULL && i == DEPTH / 2) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                cpuByte();
            end
            case (kind)
                SC_FULL: begin
                    checkOutput("wait_done_prog", cpu.prog, 1);
                    checkOutput("wait_done_ui_data", cpu.ui_data, 0);
                    cpu.cpu_done_load = 1'b1;
                end
                SC_EARLY: cpu.cpu_done_load = 1'b1;
                SC_ABORT: begin
                    wr_en   = 1'b1;
                    wr_addr = 4'd0;
                    wr_data = 8'hAA;
                    tick();
                    wr_en   = 1'b0;
                    abort   = 1'b1;
                    tick();
                    abort   = 1'b0;
                end
                SC_RESET: begin
                    #2 rst_n = 1'b0;
                    #1;
                    checkOutput("rst_prog", cpu.prog, 0);
                    checkOutput("rst_ui_data", cpu.ui_data, 0);
                    checkOutput("rst_busy", busy, 0);
                    checkOutput("rst_done", done, 0);
                    checkOutput("rst_error", error, 0);
                    checkOutput("rst_err_code", err_code, 0);
                    checkOutput("rst_byte_cnt", byte_cnt, 0);
                    tick();
                    rst_n = 1'b1;
                end
                default: ;
            endcase
        end
        waitIdle();
        cpu.cpu_done_load = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: a byte is taken when ready_for_ui falls; a load ends when busy falls.
    initial begin : monitor
        logic       ready_prev;
        logic       busy_prev;
        logic       err_prev;
        logic [7:0] seen;
        int         done_seen;
        result_t    r;
        ready_prev = 1'b0;
        busy_prev  = 1'b0;
        err_prev   = 1'b0;
        seen       = 8'h00;
        done_seen  = 0;
        forever begin
            @(negedge clk);
            if (cpu.cpu_ready && cpu.prog) seen = cpu.ui_data;
            if (ready_prev && !cpu.cpu_ready) begin
                if (exp_bytes.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL byte_extra: got %02h, required no byte", seen);
                end else begin
                    checkOutput("byte_value", seen, exp_bytes.pop_front());
                end
            end
            if (done) done_seen++;
            if (error && !err_prev) begin
                checkOutput("fail_prog", cpu.prog, 0);
                checkOutput("fail_ui_data", cpu.ui_data, 0);
            end
            if (busy_prev && !busy) begin
                if (exp_res.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL result_extra: got end of load, required none");
                end else begin
                    r = exp_res.pop_front();
                    checkOutput("done_pulses", done_seen, r.dones);
                    checkOutput("end_error", error, r.error);
                    checkOutput("end_err_code", err_code, r.code);
                    checkOutput("end_byte_cnt", byte_cnt, r.cnt);
                    checkOutput("end_prog", cpu.prog, 0);
                    checkOutput("bytes_left", exp_bytes.size(), 0);
                    exp_bytes.delete();
                end
                done_seen = 0;
            end
            ready_prev = cpu.cpu_ready;
            busy_prev  = busy;
            err_prev   = error;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got still running, required finished");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        rst_n             = 1'b0;
        wr_en             = 1'b0;
        wr_addr           = 4'd0;
        wr_data           = 8'h00;
        start             = 1'b0;
        abort             = 1'b0;
        cpu.cpu_ready     = 1'b0;
        cpu.cpu_done_load = 1'b0;
        #1;
        checkOutput("reset_prog", cpu.prog, 0);
        checkOutput("reset_ui_data", cpu.ui_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_err_code", err_code, 0);
        checkOutput("reset_byte_cnt", byte_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) writeImage(i, 8'(i + 16));
        applyStimulus(SC_FULL, 0);
        applyStimulus(SC_TIMEOUT, 0);
        randomImage();
        applyStimulus(SC_EARLY, 5);
        applyStimulus(SC_ABORT, 3);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", busy, 0);
        checkOutput("start_abort_error", error, 1);
        checkOutput("start_abort_err_code", err_code, 2'b11);
        tick();

        applyStimulus(SC_FULL, 0);
        applyStimulus(SC_RESET, 2);
        applyStimulus(SC_FULL, 0);

        for (int t = 0; t < 8; t++) begin
            int sel;
            int kind;
            int k;
            writeImage($urandom_range(0, DEPTH - 1), 8'($urandom_range(0, 255)));
            sel  = $urandom_range(0, 2);
            kind = (sel == 0) ? SC_FULL : (sel == 1) ? SC_EARLY : SC_ABORT;
            k    = $urandom_range(1, DEPTH - 1);
            applyStimulus(kind, k);
        end

        checkOutput("results_pending", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
